iir_tap_sequencer: RTL and testbench

//  Upstream control stage of the IIR datapath: holds the coefficient bank and the x/y delay lines,
//  and feeds one (coef, sample) pair per MAC operation over the start/ready handshake.

---
 rtl/iir_pkg.sv | 41 ++++
 rtl/iir_sat_shift.sv | 16 +
 rtl/iir_tap_sequencer.sv | 155 +++++++++++++++
 tb/tb_iir_tap_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// iir_pkg
//   Shared constants, sequencer state encoding and the rescale/saturate helper
//   for the IIR tap sequencer. No ports.
package iir_pkg;

    localparam int OPSIZE  = 8;
    localparam int NB      = 3;
    localparam int NA      = 2;
    localparam int SHIFT   = 7;
    localparam int NTAPS   = NB + NA;
    localparam int COEF_AW = $clog2(NTAPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_WAIT_LO,
        S_WAIT_HI,
        S_OUTPUT
    } seq_state_t;

    // Arithmetic right shift (floor) followed by a clamp to a signed op_w-bit range.
    // Works on a wide intermediate so any op_w up to 32 is handled the same way.
    function automatic logic signed [31:0] sat_shift(input logic signed [63:0] acc,
                                                     input int op_w,
                                                     input int sh);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = acc >>> sh;
        hi = (64'sd1 <<< (op_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (op_w - 1));
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/iir_sat_shift.sv
// iir_sat_shift
//   Combinational rescale of the MAC accumulator into one output sample:
//   arithmetic shift right by SHIFT, then saturate to OPSIZE bits.
// Ports
//   acc  in   2*OPSIZE  signed accumulator
//   y    out  OPSIZE    signed, saturated result
module iir_sat_shift
    import iir_pkg::*;
(
    input  logic signed [2*OPSIZE-1:0] acc,
    output logic signed [OPSIZE-1:0]   y
);

    assign y = OPSIZE'(sat_shift(64'(acc), OPSIZE, SHIFT));

endmodule

// File: rtl/iir_tap_sequencer.sv
// iir_tap_sequencer
//   Control stage in front of an external MAC for a direct-form-I IIR filter.
//   Holds the coefficient bank and the x/y delay lines, clears the MAC once per
//   sample, feeds one (coef, sample) pair per MAC operation over start/ready,
//   then rescales and saturates the accumulator into y_out.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | in_ready=1, coefficient writes allowed, waiting for a sample
//   S_CLEAR   | one-cycle MAC clear, tap index reset to 0
//   S_ISSUE   | mac_start=1 with operands of tap k
//   S_WAIT_LO | mac_start held until the MAC drops ready
//   S_WAIT_HI | waiting for the MAC to finish tap k; then next tap or output
//   S_OUTPUT  | y_out/y_valid presented, delay lines shift
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   in_valid/in_ready     sample handshake, x_in is the new x[n]
//   coef_wr/addr/data     coefficient write (0..NB-1 -> b_i, NB.. -> c_1..c_NA)
//   mac_clr, mac_start    MAC control; mac_a = coefficient, mac_b = sample
//   mac_ready, mac_acc    MAC status and accumulator
//   y_out, y_valid        filtered sample and its one-cycle strobe
module iir_tap_sequencer
    import iir_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [OPSIZE-1:0]   x_in,
    input  logic                       coef_wr,
    input  logic [COEF_AW-1:0]         coef_addr,
    input  logic signed [OPSIZE-1:0]   coef_data,
    output logic                       mac_clr,
    output logic                       mac_start,
    output logic signed [OPSIZE-1:0]   mac_a,
    output logic signed [OPSIZE-1:0]   mac_b,
    input  logic                       mac_ready,
    input  logic signed [2*OPSIZE-1:0] mac_acc,
    output logic signed [OPSIZE-1:0]   y_out,
    output logic                       y_valid
);

    localparam int KW = $clog2(NTAPS + 1);

    seq_state_t state, state_nxt;
    logic [KW-1:0] k;
    logic signed [OPSIZE-1:0] coef [NTAPS];
    logic signed [OPSIZE-1:0] x_dl [NB];
    logic signed [OPSIZE-1:0] y_dl [NA];
    logic signed [OPSIZE-1:0] samp [NTAPS];
    logic signed [OPSIZE-1:0] y_sat;
    logic accept;
    logic tap_done;
    logic last_tap;

    assign in_ready = (state == S_IDLE) && reset;
    assign accept   = in_valid && in_ready;
    assign tap_done = (state == S_WAIT_HI) && mac_ready;
    assign last_tap = (k == KW'(NTAPS - 1));

    iir_sat_shift u_sat (
        .acc (mac_acc),
        .y   (y_sat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mac_clr   = 1'b0;
        mac_start = 1'b0;
        case (state)
            S_IDLE:    if (accept) state_nxt = S_CLEAR;
            S_CLEAR: begin
                mac_clr   = 1'b1;
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                mac_start = 1'b1;
                state_nxt = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                mac_start = 1'b1;
                if (!mac_ready) state_nxt = S_WAIT_HI;
            end
            S_WAIT_HI: if (mac_ready) state_nxt = last_tap ? S_OUTPUT : S_ISSUE;
            S_OUTPUT:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // One flat view of the sample operands in tap order: x[n]..x[n-NB+1], y[n-1]..y[n-NA].
    always_comb begin
        for (int i = 0; i < NB; i++) samp[i] = x_dl[i];
        for (int j = 0; j < NA; j++) samp[NB + j] = y_dl[j];
    end

    // Operands only driven while a tap is in flight; k stays put until WAIT_HI exits.
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        if (state inside {S_ISSUE, S_WAIT_LO, S_WAIT_HI}) begin
            for (int i = 0; i < NTAPS; i++) begin
                if (k == KW'(i)) begin
                    mac_a = coef[i];
                    mac_b = samp[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k       <= '0;
            y_out   <= '0;
            y_valid <= 1'b0;
            for (int i = 0; i < NTAPS; i++) coef[i] <= '0;
            for (int i = 0; i < NB; i++)    x_dl[i] <= '0;
            for (int j = 0; j < NA; j++)    y_dl[j] <= '0;
        end else begin
            y_valid <= 1'b0;
            if ((state == S_IDLE) && coef_wr && (coef_addr < COEF_AW'(NTAPS))) begin
                coef[coef_addr] <= coef_data;
            end
            if (accept) begin
                x_dl[0] <= x_in;
            end
            if (state == S_CLEAR) begin
                k <= '0;
            end
            // The accumulator already holds the last product when ready rises,
            // so the result is registered here and is visible throughout OUTPUT.
            if (tap_done) begin
                k <= k + 1'b1;
                if (last_tap) begin
                    y_out   <= y_sat;
                    y_valid <= 1'b1;
                end
            end
            if (state == S_OUTPUT) begin
                for (int i = 1; i < NB; i++) x_dl[i] <= x_dl[i - 1];
                y_dl[0] <= y_out;
                for (int j = 1; j < NA; j++) y_dl[j] <= y_dl[j - 1];
            end
        end
    end

endmodule

// File: tb/tb_iir_tap_sequencer.sv
module tb_iir_tap_sequencer;
    import iir_pkg::*;

    localparam int T_MAC = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic in_ready;
    logic signed [OPSIZE-1:0] x_in;
    logic coef_wr;
    logic [COEF_AW-1:0] coef_addr;
    logic signed [OPSIZE-1:0] coef_data;
    logic mac_clr;
    logic mac_start;
    logic signed [OPSIZE-1:0] mac_a;
    logic signed [OPSIZE-1:0] mac_b;
    logic mac_ready;
    logic signed [2*OPSIZE-1:0] mac_acc;
    logic signed [OPSIZE-1:0] y_out;
    logic y_valid;

    always #5 clk = ~clk;

    iir_tap_sequencer dut (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .coef_wr   (coef_wr),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .mac_clr   (mac_clr),
        .mac_start (mac_start),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_ready (mac_ready),
        .mac_acc   (mac_acc),
        .y_out     (y_out),
        .y_valid   (y_valid)
    );

    // MAC model: accepts start while ready, busy for T_MAC cycles, accumulates as ready rises.
    logic signed [OPSIZE-1:0] ra, rb;
    int mac_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_acc   <= '0;
            mac_ready <= 1'b1;
            mac_cnt   <= 0;
            ra        <= '0;
            rb        <= '0;
        end else if (mac_clr) begin
            mac_acc   <= '0;
            mac_ready <= 1'b1;
            mac_cnt   <= 0;
        end else if (mac_ready) begin
            if (mac_start) begin
                mac_ready <= 1'b0;
                mac_cnt   <= T_MAC - 1;
                ra        <= mac_a;
                rb        <= mac_b;
            end
        end else if (mac_cnt == 0) begin
            mac_ready <= 1'b1;
            mac_acc   <= mac_acc + (16'(ra) * 16'(rb));
        end else begin
            mac_cnt <= mac_cnt - 1;
        end
    end

    int total = 0;
    int bad = 0;
    int yq[$];
    int pulses = 0;
    int accepts = 0;

    always @(negedge clk) begin
        if (y_valid) begin
            yq.push_back(int'(y_out));
            pulses++;
        end
        if (in_valid && in_ready) accepts++;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        coef_wr  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        yq.delete();
        pulses  = 0;
        accepts = 0;
    endtask

    task automatic wr_coef(input int addr, input int data);
        @(negedge clk);
        coef_wr   = 1'b1;
        coef_addr = COEF_AW'(addr);
        coef_data = OPSIZE'(data);
        @(posedge clk);
        #1 coef_wr = 1'b0;
    endtask

    task automatic send(input int x);
        int n;
        n = 0;
        @(negedge clk);
        x_in     = OPSIZE'(x);
        in_valid = 1'b1;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("accept", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic get_y(output int y);
        int n;
        n = 0;
        while (yq.size() == 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (yq.size() > 0) y = yq.pop_front();
        else y = -999;
    endtask

    task automatic run_pair(input string tag, input int x, input int exp);
        int y;
        send(x);
        get_y(y);
        check(tag, y, exp);
    endtask

    initial begin
        int y, cyc, n;
        int xs[3];
        bit wrote;
        xs = '{10, 20, 30};
        rst_n = 1'b0; in_valid = 1'b0; x_in = '0;
        coef_wr = 1'b0; coef_addr = '0; coef_data = '0;

        // reset state
        #12;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_y_out", int'(y_out), 0);
        check("rst_y_valid", int'(y_valid), 0);
        check("rst_mac_start", int'(mac_start), 0);
        check("rst_mac_clr", int'(mac_clr), 0);
        do_reset();
        #1 check("idle_in_ready", int'(in_ready), 1);

        // 1 gain, coefficient written in the accept cycle, latency, single pulse
        @(negedge clk);
        coef_wr = 1'b1; coef_addr = '0; coef_data = 8'sd64;
        x_in = 8'sd100; in_valid = 1'b1;
        @(posedge clk);
        #1 coef_wr = 1'b0; in_valid = 1'b0;
        cyc = 0;
        while (!y_valid && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("t1_latency", cyc, 27);
        get_y(y);
        check("t1_gain", y, 50);
        repeat (10) @(negedge clk);
        check("t1_pulses", pulses, 1);
        check("t1_y_hold", int'(y_out), 50);

        // 2 delay
        do_reset();
        wr_coef(1, 64);
        run_pair("t2_y0", 100, 0);
        run_pair("t2_y1", 0, 50);

        // 3 feedback
        do_reset();
        wr_coef(0, 64);
        wr_coef(3, 64);
        run_pair("t3_y0", 100, 50);
        run_pair("t3_y1", 0, 25);
        run_pair("t3_y2", 0, 12);

        // 4 saturation both ways
        do_reset();
        wr_coef(0, 127);
        wr_coef(1, 127);
        run_pair("t4_pos0", 127, 126);
        run_pair("t4_pos1", 127, 127);
        do_reset();
        wr_coef(0, 127);
        wr_coef(1, 127);
        run_pair("t4_neg0", -128, -127);
        run_pair("t4_neg1", -128, -128);

        // 5 backpressure with in_valid held high; coefficient write while busy is dropped
        do_reset();
        wr_coef(0, 64);
        n = 0; cyc = 0; wrote = 1'b0;
        @(negedge clk);
        x_in = OPSIZE'(xs[0]);
        in_valid = 1'b1;
        while (n < 3 && cyc < 2000) begin
            if (in_ready) begin
                n++;
                @(posedge clk);
                #1;
                if (n < 3) x_in = OPSIZE'(xs[n]);
                else in_valid = 1'b0;
            end else if (n == 1 && !wrote) begin
                wrote = 1'b1;
                coef_wr = 1'b1; coef_addr = '0; coef_data = '0;
                @(posedge clk);
                #1 coef_wr = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        get_y(y); check("t5_y0", y, 5);
        get_y(y); check("t5_y1", y, 10);
        get_y(y); check("t5_y2", y, 15);
        check("t5_accepts", accepts, 3);
        run_pair("t5_after", 40, 20);

        // 6 reset during WAIT_HI
        do_reset();
        wr_coef(0, 64);
        run_pair("t6_pre", 100, 50);
        send(100);
        n = 0;
        while (dut.state != S_WAIT_HI && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_in_wait_hi", int'(dut.state == S_WAIT_HI), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_y_out", int'(y_out), 0);
        check("t6_y_valid", int'(y_valid), 0);
        check("t6_in_ready", int'(in_ready), 0);
        check("t6_mac_start", int'(mac_start), 0);
        check("t6_mac_clr", int'(mac_clr), 0);
        check("t6_mac_a", int'(mac_a), 0);
        check("t6_mac_b", int'(mac_b), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        yq.delete();
        pulses = 0;
        repeat (40) @(negedge clk);
        check("t6_discarded", pulses, 0);
        wr_coef(0, 64);
        run_pair("t6_replay", 100, 50);
        repeat (5) @(negedge clk);
        check("t6_pulses", pulses, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
